// File: rtl/text_cursor_ctrl.sv
// Write-port master for the text-mode tile RAM. It turns button edges into single-cycle
// character writes at a wrapping cursor, and it runs a full-screen clear sweep.
module text_cursor_ctrl #(
    parameter int         COLS         = 80,
    parameter int         ROWS         = 30,
    parameter logic [6:0] BLANK        = 7'h20,
    parameter bit         CLR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        set,
    input  logic        up,
    input  logic        down,
    input  logic        left,
    input  logic        right,
    input  logic        clr,
    input  logic [6:0]  sw,
    output logic        we,
    output logic [11:0] addr,
    output logic [6:0]  din,
    output logic [6:0]  cur_x,
    output logic [4:0]  cur_y,
    output logic        busy
);

    localparam logic [6:0] X_MAX = 7'(COLS - 1);
    localparam logic [4:0] Y_MAX = 5'(ROWS - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  prev_q, prev_d;
    logic [6:0]  sx_q, sx_d;
    logic [4:0]  sy_q, sy_d;
    logic [6:0]  cx_q, cx_d;
    logic [4:0]  cy_q, cy_d;
    logic        we_q, we_d;
    logic [11:0] addr_q, addr_d;
    logic [6:0]  din_q, din_d;
    logic        busy_q, busy_d;

    logic [5:0]  btn;
    logic [5:0]  edges;
    logic        sweep;
    logic [6:0]  bx;
    logic [4:0]  by;

    // Bit order sets priority: clr highest, right lowest.
    assign btn   = {clr, set, up, down, left, right};
    assign edges = btn & ~prev_q;

    always_comb begin
        state_d = state_q;
        prev_d  = btn;
        sx_d    = sx_q;
        sy_d    = sy_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        busy_d  = busy_q;
        sweep   = 1'b0;
        bx      = sx_q;
        by      = sy_q;

        case (state_q)
            ST_CLEAR: sweep = 1'b1;
            ST_IDLE: begin
                busy_d = 1'b0;
                if (edges[5]) begin
                    // The clr edge itself issues the first blank write at (0,0).
                    sweep = 1'b1;
                    bx    = '0;
                    by    = '0;
                    cx_d  = '0;
                    cy_d  = '0;
                end else if (edges[4]) begin
                    we_d   = 1'b1;
                    addr_d = {cy_q, cx_q};
                    din_d  = sw;
                    if (cx_q == X_MAX) begin
                        cx_d = '0;
                        cy_d = (cy_q == Y_MAX) ? '0 : cy_q + 5'd1;
                    end else begin
                        cx_d = cx_q + 7'd1;
                    end
                end else if (edges[3]) begin
                    cy_d = (cy_q == '0) ? Y_MAX : cy_q - 5'd1;
                end else if (edges[2]) begin
                    cy_d = (cy_q == Y_MAX) ? '0 : cy_q + 5'd1;
                end else if (edges[1]) begin
                    cx_d = (cx_q == '0) ? X_MAX : cx_q - 7'd1;
                end else if (edges[0]) begin
                    cx_d = (cx_q == X_MAX) ? '0 : cx_q + 7'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // busy stays high through the final write and drops with we one cycle later.
        if (sweep) begin
            we_d    = 1'b1;
            addr_d  = {by, bx};
            din_d   = BLANK;
            busy_d  = 1'b1;
            state_d = ST_CLEAR;
            if (bx == X_MAX) begin
                sx_d = '0;
                if (by == Y_MAX) begin
                    sy_d    = '0;
                    state_d = ST_IDLE;
                end else begin
                    sy_d = by + 5'd1;
                end
            end else begin
                sx_d = bx + 7'd1;
                sy_d = by;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= CLR_ON_RESET ? ST_CLEAR : ST_IDLE;
            busy_q  <= CLR_ON_RESET;
            prev_q  <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            prev_q  <= prev_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    assign we    = we_q;
    assign addr  = addr_q;
    assign din   = din_q;
    assign cur_x = cx_q;
    assign cur_y = cy_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Randomised and directed bench for text_cursor_ctrl, checked every cycle against a
// linear-index model of the cursor and the clear sweep.
module tb_text_cursor_ctrl;

    localparam int         COLS  = 80;
    localparam int         ROWS  = 30;
    localparam logic [6:0] BLANK = 7'h20;
    localparam bit         CLR_ON_RESET = 1'b1;

    localparam logic [5:0] B_CLR   = 6'b100000;
    localparam logic [5:0] B_SET   = 6'b010000;
    localparam logic [5:0] B_UP    = 6'b001000;
    localparam logic [5:0] B_DOWN  = 6'b000100;
    localparam logic [5:0] B_LEFT  = 6'b000010;
    localparam logic [5:0] B_RIGHT = 6'b000001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  btn;
    logic [6:0]  sw;
    logic        we;
    logic [11:0] addr;
    logic [6:0]  din;
    logic [6:0]  cur_x;
    logic [4:0]  cur_y;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    // model state
    logic [5:0]  m_prev;
    int          m_x, m_y, m_idx;
    logic        m_we, m_busy;
    logic [11:0] m_addr;
    logic [6:0]  m_din;

    text_cursor_ctrl #(
        .COLS(COLS), .ROWS(ROWS), .BLANK(BLANK), .CLR_ON_RESET(CLR_ON_RESET)
    ) dut (
        .clk(clk), .reset(rst_n),
        .set(btn[4]), .up(btn[3]), .down(btn[2]), .left(btn[1]), .right(btn[0]),
        .clr(btn[5]), .sw(sw),
        .we(we), .addr(addr), .din(din), .cur_x(cur_x), .cur_y(cur_y), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic model_step();
        logic [5:0] e;
        int p;
        if (!rst_n) begin
            m_prev = '0; m_x = 0; m_y = 0; m_we = 1'b0; m_addr = '0; m_din = '0;
            m_idx  = CLR_ON_RESET ? 0 : -1;
            m_busy = CLR_ON_RESET;
            return;
        end
        e      = btn & ~m_prev;
        m_prev = btn;
        m_we   = 1'b0;
        if (m_idx < 0) begin
            m_busy = 1'b0;
            if (e[5]) begin
                m_x = 0; m_y = 0; m_idx = 0;
            end else if (e[4]) begin
                m_we   = 1'b1;
                m_addr = 12'(m_y * 128 + m_x);
                m_din  = sw;
                p   = (m_y * COLS + m_x + 1) % (COLS * ROWS);
                m_x = p % COLS;
                m_y = p / COLS;
            end else if (e[3]) m_y = (m_y + ROWS - 1) % ROWS;
            else if (e[2]) m_y = (m_y + 1) % ROWS;
            else if (e[1]) m_x = (m_x + COLS - 1) % COLS;
            else if (e[0]) m_x = (m_x + 1) % COLS;
        end
        if (m_idx >= 0) begin
            m_we   = 1'b1;
            m_addr = 12'((m_idx / COLS) * 128 + m_idx % COLS);
            m_din  = BLANK;
            m_busy = 1'b1;
            m_idx++;
            if (m_idx == COLS * ROWS) m_idx = -1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("we",    32'(we),    32'(m_we));
        check("busy",  32'(busy),  32'(m_busy));
        check("cur_x", 32'(cur_x), 32'(m_x));
        check("cur_y", 32'(cur_y), 32'(m_y));
        check("addr",  32'(addr),  32'(m_addr));
        check("din",   32'(din),   32'(m_din));
    endtask

    task automatic press(input logic [5:0] m);
        btn = m;
        tick();
    endtask

    task automatic release_all();
        btn = '0;
        tick();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0; btn = '0; sw = '0;
        ticks(3);
        check("rst_we", 32'(we), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_addr", 32'(addr), 32'd0);

        // reset-release sweep
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 2405; i++) begin
            tick();
            if (i == 0) check("sweep_first_addr", 32'(addr), 32'h000);
            if (i == 80) check("sweep_row1_addr", 32'(addr), 32'h080);
            if (i == 2399) check("sweep_last_addr", 32'(addr), 32'hECF);
            if (we) cnt++;
        end
        check("sweep_len", 32'(cnt), 32'd2400);
        check("sweep_done_busy", 32'(busy), 32'd0);

        // writes and boundary moves
        sw = 7'h41;
        press(B_SET);
        check("set0_addr", 32'(addr), 32'h000);
        check("set0_din", 32'(din), 32'h41);
        check("set0_x", 32'(cur_x), 32'd1);
        release_all();
        press(B_LEFT); release_all();
        press(B_LEFT); release_all();
        press(B_UP);   release_all();
        check("to_corner_x", 32'(cur_x), 32'd79);
        check("to_corner_y", 32'(cur_y), 32'd29);
        sw = 7'h42;
        press(B_SET);
        check("corner_addr", 32'(addr), 32'hECF);
        check("corner_wrap_x", 32'(cur_x), 32'd0);
        check("corner_wrap_y", 32'(cur_y), 32'd0);
        release_all();
        press(B_UP);    check("up_wrap_y", 32'(cur_y), 32'd29); release_all();
        press(B_LEFT);  check("left_wrap_x", 32'(cur_x), 32'd79); release_all();
        press(B_RIGHT); check("right_wrap_x", 32'(cur_x), 32'd0);
        check("right_no_carry_y", 32'(cur_y), 32'd29); release_all();
        press(B_DOWN);  check("down_wrap_y", 32'(cur_y), 32'd0); release_all();

        // held set gives one write; set+right does only the set
        btn = B_SET;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (we) cnt++;
        end
        check("held_set_writes", 32'(cnt), 32'd1);
        release_all();
        press(B_SET | B_RIGHT);
        check("set_right_we", 32'(we), 32'd1);
        check("set_right_addr", 32'(addr), 32'h001);
        check("set_right_x", 32'(cur_x), 32'd2);
        release_all();

        // clr from (5,3) with a set dropped mid-sweep
        while (m_x != 5) begin press(B_RIGHT); release_all(); end
        while (m_y != 3) begin press(B_DOWN);  release_all(); end
        press(B_CLR);
        check("clr_busy", 32'(busy), 32'd1);
        check("clr_home_x", 32'(cur_x), 32'd0);
        check("clr_first_addr", 32'(addr), 32'h000);
        cnt = 1;
        btn = '0;
        for (int i = 0; i < 2450; i++) begin
            btn = (i == 100) ? B_SET : 6'b0;
            tick();
            if (we) cnt++;
        end
        check("clr_sweep_len", 32'(cnt), 32'd2400);

        // reset during sweep restarts from address 0
        press(B_CLR);
        release_all();
        ticks(998);
        rst_n = 1'b0;
        tick();
        check("abort_we", 32'(we), 32'd0);
        rst_n = 1'b1;
        tick();
        check("restart_addr", 32'(addr), 32'h000);
        check("restart_we", 32'(we), 32'd1);
        ticks(2420);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            btn[4:0] = 5'($urandom_range(0, 31));
            btn[5]   = ($urandom_range(0, 999) == 0);
            sw       = 7'($urandom_range(0, 127));
            rst_n    = ($urandom_range(0, 2999) != 0);
            tick();
        end
        rst_n = 1'b1;
        btn = '0;
        ticks(2500);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
